// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared entry type and default sizing for the fetch queue
package fetch_queue_pkg;
    localparam int FQ_DEPTH  = 4;
    localparam int FQ_AWIDTH = 32;
    localparam int FQ_DWIDTH = 32;
    typedef struct packed {
        logic [FQ_AWIDTH-1:0] pc;
        logic [FQ_DWIDTH-1:0] insn;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: PC/instruction FIFO between fetch and decode; FETCH_QUEUE_BYPASS_EN enables empty-queue bypass
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int AWIDTH = FQ_AWIDTH,
    parameter int DWIDTH = FQ_DWIDTH,
    parameter int DEPTH  = FQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       enq_valid_i,
    output logic                       enq_ready_o,
    input  logic [AWIDTH-1:0]          enq_pc_i,
    input  logic [DWIDTH-1:0]          enq_insn_i,
    output logic                       deq_valid_o,
    input  logic                       deq_ready_i,
    output logic [AWIDTH-1:0]          deq_pc_o,
    output logic [DWIDTH-1:0]          deq_insn_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fq_entry_t       mem [DEPTH];
    fq_entry_t       head;
    logic [PW-1:0]   wp, rp;
    logic [CW-1:0]   count;
    logic            active, byp, do_wr, do_rd;

    assign count_o = count;

    // handshakes, head selection and the effective write/read strobes
    always_comb begin
        active      = rst && !flush_i;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp         = active && count == '0 && enq_valid_i;
        head        = byp ? '{pc: FQ_AWIDTH'(enq_pc_i), insn: FQ_DWIDTH'(enq_insn_i)} : mem[rp];
`else
        byp         = 1'b0;
        head        = mem[rp];
`endif
        enq_ready_o = active && count < CW'(DEPTH);
        deq_valid_o = active && (count != '0 || byp);
        deq_pc_o    = deq_valid_o ? AWIDTH'(head.pc) : '0;
        deq_insn_o  = deq_valid_o ? DWIDTH'(head.insn) : '0;
        do_wr       = enq_valid_i && enq_ready_o && !(byp && deq_ready_i);
        do_rd       = deq_valid_o && deq_ready_i && !byp;
    end

    // pointers and occupancy; reset and flush both empty the queue
    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + PW'(do_wr);
            rp    <= rp + PW'(do_rd);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    // entry storage, written only on an accepted enqueue, never reset
    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= '{pc: FQ_AWIDTH'(enq_pc_i), insn: FQ_DWIDTH'(enq_insn_i)};
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed plus random stimulus against a queue-based scoreboard
module tb_fetch_queue;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH+1);
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush_i = 1'b0;
    logic          enq_valid_i = 1'b0;
    logic          enq_ready_o;
    logic [AW-1:0] enq_pc_i = '0;
    logic [DW-1:0] enq_insn_i = '0;
    logic          deq_valid_o;
    logic          deq_ready_i = 1'b0;
    logic [AW-1:0] deq_pc_o;
    logic [DW-1:0] deq_insn_o;
    logic [CW-1:0] count_o;

    fetch_queue #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
        .enq_pc_i(enq_pc_i), .enq_insn_i(enq_insn_i),
        .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
        .deq_pc_o(deq_pc_o), .deq_insn_o(deq_insn_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          mon_on = 1'b0;
    logic [63:0] q[$];
    int          occ_neg = 0;
    bit          byp_neg = 1'b0;
    int          occ;
    logic        act_m, byp_m, exp_v;
    logic [63:0] head;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic ev, input logic [AW-1:0] pc, input logic [DW-1:0] insn,
                          input logic dr, input logic fl);
        enq_valid_i = ev;
        enq_pc_i    = pc;
        enq_insn_i  = insn;
        deq_ready_i = dr;
        flush_i     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor: compare outputs to the model mid-cycle and retire consumed entries
    always @(negedge clk) begin
        if (mon_on) begin
            occ   = q.size();
            act_m = rst && !flush_i;
            byp_m = BYP && act_m && occ == 0 && enq_valid_i;
            exp_v = act_m && (occ > 0 || byp_m);
            head  = byp_m ? {enq_pc_i, enq_insn_i} : (occ > 0 ? q[0] : 64'h0);
            chk("count", 64'(count_o), 64'(occ));
            chk("enq_ready", 64'(enq_ready_o), 64'(act_m && occ < DEPTH));
            chk("deq_valid", 64'(deq_valid_o), 64'(exp_v));
            chk("deq_pc", 64'(deq_pc_o), exp_v ? 64'(head[63:32]) : 64'h0);
            chk("deq_insn", 64'(deq_insn_o), exp_v ? 64'(head[31:0]) : 64'h0);
            if (exp_v && deq_ready_i && !byp_m) void'(q.pop_front());
            occ_neg = occ;
            byp_neg = byp_m;
        end
    end

    // scoreboard push: an offer is accepted when the model had room and it was not bypassed away
    always @(posedge clk) begin
        if (!rst || flush_i) q.delete();
        else if (enq_valid_i && occ_neg < DEPTH && !(byp_neg && deq_ready_i))
            q.push_back({enq_pc_i, enq_insn_i});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(0, '0, '0, 0, 0);
        step();
        mon_on = 1'b1;
        step();
        rst = 1'b1;
        #2;
        chk("reset_count", 64'(count_o), 64'd0);
        chk("reset_ready", 64'(enq_ready_o), 64'd1);
        chk("reset_valid", 64'(deq_valid_o), 64'd0);
        chk("reset_pc", 64'(deq_pc_o), 64'd0);
        step();

        for (int i = 0; i < 4; i++) begin
            set_in(1, 32'h1000 + 32'(4*i), 32'hA000_0000 + 32'(i), 0, 0);
            step();
        end
        set_in(0, '0, '0, 0, 0);
        #2;
        chk("full_count", 64'(count_o), 64'd4);
        chk("full_ready", 64'(enq_ready_o), 64'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            set_in(0, '0, '0, 1, 0);
            #2;
            chk("drain_pc", 64'(deq_pc_o), 64'(32'h1000 + 32'(4*i)));
            chk("drain_insn", 64'(deq_insn_o), 64'(32'hA000_0000 + 32'(i)));
            step();
        end

        for (int i = 0; i < 4; i++) begin
            set_in(1, 32'h1100 + 32'(4*i), 32'hB000_0000 + 32'(i), 0, 0);
            step();
        end
        set_in(1, 32'h3000, 32'h3, 1, 0);
        #2;
        chk("full_deq_ready", 64'(enq_ready_o), 64'd0);
        step();
        set_in(0, '0, '0, 0, 0);
        #2;
        chk("after_full_count", 64'(count_o), 64'd3);
        chk("after_full_ready", 64'(enq_ready_o), 64'd1);
        step();
        set_in(0, '0, '0, 1, 0);
        step();

        for (int i = 0; i < 6; i++) begin
            set_in(1, 32'h4000 + 32'(4*i), 32'hC000_0000 + 32'(i), 1, 0);
            step();
        end
        set_in(0, '0, '0, 0, 0);
        #2;
        chk("wrap_count", 64'(count_o), 64'd2);
        step();

        set_in(1, 32'h4800, 32'hD, 0, 0);
        step();
        set_in(1, 32'h5000, 32'hE, 0, 1);
        #2;
        chk("flush_valid", 64'(deq_valid_o), 64'd0);
        step();
        set_in(0, '0, '0, 0, 0);
        #2;
        chk("post_flush_count", 64'(count_o), 64'd0);
        chk("post_flush_valid", 64'(deq_valid_o), 64'd0);
        step();

        set_in(1, 32'h2000, 32'h2222, 1, 0);
        #2;
        chk("bypass_valid", 64'(deq_valid_o), 64'(BYP));
        chk("bypass_pc", 64'(deq_pc_o), BYP ? 64'h2000 : 64'h0);
        step();
        set_in(0, '0, '0, 0, 0);
        #2;
        chk("bypass_next_count", 64'(count_o), BYP ? 64'd0 : 64'd1);
        chk("bypass_next_valid", 64'(deq_valid_o), BYP ? 64'd0 : 64'd1);
        chk("bypass_next_pc", 64'(deq_pc_o), BYP ? 64'h0 : 64'h2000);
        step();
        set_in(0, '0, '0, 1, 0);
        step();

        for (int i = 0; i < 2; i++) begin
            set_in(1, 32'h6000 + 32'(4*i), 32'h6, 0, 0);
            step();
        end
        set_in(0, '0, '0, 0, 0);
        rst = 1'b0;
        #2;
        chk("in_reset_ready", 64'(enq_ready_o), 64'd0);
        chk("in_reset_valid", 64'(deq_valid_o), 64'd0);
        chk("in_reset_pc", 64'(deq_pc_o), 64'd0);
        step();
        rst = 1'b1;
        #2;
        chk("post_reset_ready", 64'(enq_ready_o), 64'd1);
        chk("post_reset_valid", 64'(deq_valid_o), 64'd0);
        chk("post_reset_count", 64'(count_o), 64'd0);
        step();

        for (int n = 0; n < 3000; n++) begin
            rst = $urandom_range(0, 99) != 0;
            set_in($urandom_range(0, 2) != 0, $urandom, $urandom,
                   $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
            step();
        end
        rst = 1'b1;
        set_in(0, '0, '0, 1, 0);
        repeat (DEPTH + 2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
